sync_fifo: RTL



---
 rtl/fifo_pkg.sv | 31 +++
 rtl/sync_fifo_if.sv | 29 ++
 rtl/fifo_mem.sv | 40 ++++
 rtl/sync_fifo_chk.sv | 15 +
 rtl/sync_fifo.sv | 98 +++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, the data word type and the
// operation kind used by the driver and monitor side of the FIFO bus.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef logic [DATA_W_DEF-1:0] fifo_data_t;

    // One bus operation per cycle, as issued by a driver or seen by a monitor.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WR    = 2'd1,
        OP_RD    = 2'd2,
        OP_WR_RD = 2'd3
    } fifo_op_e;

    // Map an operation kind onto the wr/rd request pair {wr, rd}.
    function automatic logic [1:0] op_to_req(input fifo_op_e op);
        logic [1:0] req;
        case (op)
            OP_IDLE:  req = 2'b00;
            OP_WR:    req = 2'b10;
            OP_RD:    req = 2'b01;
            OP_WR_RD: req = 2'b11;
            default:  req = 2'b00;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// FIFO bus: request/data from the driver side, read data and status from the
// FIFO side.
//   master : drives wr, rd, data_in; observes data_out and status.
//   slave  : the FIFO itself; drives data_out, full, empty, count,
//            overflow, underflow.
interface sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                     wr;
    logic                     rd;
    logic [DATA_W-1:0]        data_in;
    logic [DATA_W-1:0]        data_out;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr, rd, data_in,
        input  data_out, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr, rd, data_in,
        output data_out, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage array with one synchronous write port and one registered read
// port. A read and a write to the same address in one cycle return the old
// content. Storage is not reset; only the read register is.
//   clk, rst : clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : registered read port, rdata holds when re is low
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      re,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]         rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write; non-blocking update gives read-old-data on collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read data, cleared by reset and held when no read occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/sync_fifo_chk.sv
// Protocol and consistency assertions for the FIFO bus.
//   clk, rst : clock and reset of the observed FIFO
//   wr, rd   : request lines, must be known outside reset
//   full, empty : status flags, never both high
module sync_fifo_chk (
    input logic clk,
    input logic rst,
    input logic wr,
    input logic rd,
    input logic full,
    input logic empty
);
    a_req_known: assert property (@(posedge clk) disable iff (rst) !$isunknown({wr, rd}));
    a_flags_excl: assert property (@(posedge clk) disable iff (rst) !(full && empty));
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO responding to the FIFO bus. Pointers carry an extra wrap
// bit so full and empty are distinguished without a separate flag. All
// status outputs and read data are registered.
//   clk : clock, all state updates on posedge
//   rst : asynchronous active-high reset
//   bus : sync_fifo_if slave (wr, rd, data_in, data_out, full, empty, count,
//         overflow, underflow)
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic              full_r, empty_r, overflow_r, underflow_r;
    logic              full_nxt_s, empty_nxt_s, rd_acc_s, wr_acc_s;
    logic [DATA_W-1:0] rd_data_s;

    // Accept decisions and next pointer/count/flag values from registered state.
    always_comb begin
        rd_acc_s = bus.rd && !empty_r;
        // A read in the same cycle frees the slot, so a full FIFO still accepts.
        wr_acc_s = bus.wr && (!full_r || rd_acc_s);

        if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase

        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s  = (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]) &&
                      (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]);
    end

    // Pointer, occupancy, flag and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            full_r      <= full_nxt_s;
            empty_r     <= empty_nxt_s;
            overflow_r  <= bus.wr && !wr_acc_s;
            underflow_r <= bus.rd && empty_r;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (bus.data_in),
        .re    (rd_acc_s),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (rd_data_s)
    );

    assign bus.data_out  = rd_data_s;
    assign bus.full      = full_r;
    assign bus.empty     = empty_r;
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
endmodule
